// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants, request kinds and the loader FSM state type.
// Also used by the pipeline's opcode/funct3 decoder.
package rv32_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_WORD    = 3'b010;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    KIND_ADDI = 3'd0,
    KIND_ADD  = 3'd1,
    KIND_SUB  = 3'd2,
    KIND_LW   = 3'd3,
    KIND_SW   = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2,
    ST_ERR  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I word assembly from request kind and fields.
// Unknown kinds produce the NOP word.
module instr_field_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = NOP_WORD;
    case (kind)
      KIND_ADDI: word = {imm, rs1, F3_ADD_SUB, rd, OPC_OP_IMM};
      KIND_ADD:  word = {F7_ADD, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      KIND_SUB:  word = {F7_SUB, rs2, rs1, F3_ADD_SUB, rd, OPC_OP};
      KIND_LW:   word = {imm, rs1, F3_WORD, rd, OPC_LOAD};
      // S-format splits the immediate around the register fields
      KIND_SW:   word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
      default:   word = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes field-level requests and writes them to consecutive imem words.
// Define INSTR_ENCODER_ILLEGAL_ERR_EN to trap illegal kinds in an ERR state instead of writing NOPs.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting requests, one imem write per accept
// FIN   | one-cycle done pulse, then back to IDLE
// ERR   | illegal kind seen (optional), held until start
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int AW   = 6,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [11:0]   in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
  output logic          err,
`endif
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_BASE = BASE[AW-1:0];
  localparam logic [AW-1:0] PTR_MAX  = {AW{1'b1}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  enc_state_e    state, state_nxt;
  logic [AW-1:0] ptr;
  logic [31:0]   word;
  logic          accept;
  logic          write_ok;

  instr_field_pack u_pack (
    .kind (in_kind),
    .rd   (in_rd),
    .rs1  (in_rs1),
    .rs2  (in_rs2),
    .imm  (in_imm),
    .word (word)
  );

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state == ST_LOAD);
  assign done     = (state == ST_FIN);
  assign accept   = in_valid & in_ready;

`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
  logic illegal;
  assign illegal  = (in_kind > KIND_SW);
  assign write_ok = accept & ~illegal;
`else
  assign write_ok = accept;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
        if (accept && illegal) state_nxt = ST_ERR;
        else
`endif
        // capacity stop: the word just accepted lands in the last slot
        if (accept && (in_last || ptr == PTR_MAX)) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
      ST_ERR:  if (start) state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= PTR_BASE;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= write_ok;
      if (write_ok) begin
        imem_addr  <= ptr;
        imem_wdata <= word;
        ptr        <= ptr + PTR_ONE;
        count      <= count + CNT_ONE;
      end
      if (state == ST_IDLE && start) begin
        ptr   <= PTR_BASE;
        count <= '0;
      end
    end
  end

`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && illegal) begin
      err <= 1'b1;
    end else if (state == ST_ERR && start) begin
      err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a 64-word instance for encoding/session tests
// and a 4-word instance for the capacity stop.
`timescale 1ns/1ps
module tb_instr_encoder;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [2:0]  kind = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [11:0] imm = '0;
  logic        last = 1'b0;

  logic        ready_a, we_a, busy_a, done_a;
  logic [5:0]  addr_a;
  logic [31:0] wdata_a;
  logic [6:0]  count_a;
  logic        ready_b, we_b, busy_b, done_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;
`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
  logic        err_a, err_b;
`endif

  int checks = 0;
  int errors = 0;
  wr_t q_a[$];
  wr_t q_b[$];

  instr_encoder #(.AW(6), .BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_kind(kind), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_last(last),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .busy(busy_a), .done(done_a),
`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
    .err(err_a),
`endif
    .count(count_a)
  );

  instr_encoder #(.AW(2), .BASE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_kind(kind), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_last(last),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .busy(busy_b), .done(done_b),
`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
    .err(err_b),
`endif
    .count(count_b)
  );

  // write monitors: every strobe must match the oldest pending expectation
  always @(negedge clk) begin
    wr_t e;
    if (we_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a_unexpected addr=%0d data=%h", addr_a, wdata_a);
      end else begin
        e = q_a.pop_front();
        if (addr_a !== e.addr || wdata_a !== e.data) begin
          errors++;
          $display("FAIL wr_a addr=%0d data=%h exp addr=%0d data=%h", addr_a, wdata_a, e.addr, e.data);
        end
      end
    end
    if (we_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b_unexpected addr=%0d data=%h", addr_b, wdata_b);
      end else begin
        e = q_b.pop_front();
        if ({4'b0, addr_b} !== e.addr || wdata_b !== e.data) begin
          errors++;
          $display("FAIL wr_b addr=%0d data=%h exp addr=%0d data=%h", addr_b, wdata_b, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input bit sel_b);
    @(posedge clk); #1;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // drive one request; returns just after its accepting edge
  task automatic send(input bit sel_b, input logic [2:0] k, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im,
                      input logic l, input bit exp_wr, input logic [5:0] ea, input logic [31:0] ed);
    bit got;
    wr_t w;
    got = 1'b0;
    kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im; last = l;
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel_b ? ready_b : ready_a) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout kind=%0d got=0 exp=1", k);
    end else begin
      @(posedge clk); #1;
      if (exp_wr) begin
        w.addr = ea;
        w.data = ed;
        if (sel_b) q_b.push_back(w); else q_a.push_back(w);
      end
    end
  endtask

  task automatic idle_inputs();
    valid_a = 1'b0;
    valid_b = 1'b0;
    last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired=1 exp=0");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, ready_a}, 32'd0);
    check("rst_we", {31'b0, we_a}, 32'd0);
    check("rst_addr", {26'b0, addr_a}, 32'd0);
    check("rst_wdata", wdata_a, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_done", {31'b0, done_a}, 32'd0);
    check("rst_count", {25'b0, count_a}, 32'd0);

    // in_valid while IDLE: nothing accepted, nothing written
    @(posedge clk); #1;
    kind = 3'd0; rd = 5'd9; imm = 12'd1; valid_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", {31'b0, ready_a}, 32'd0);
    end
    idle_inputs();

    // single ADDI x1,x0,5 session
    pulse_start(1'b0);
    check("load_busy", {31'b0, busy_a}, 32'd1);
    send(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5, 1'b1, 1'b1, 6'd0, 32'h0050_0093);
    idle_inputs();
    @(negedge clk);
    check("addi_done", {31'b0, done_a}, 32'd1);
    check("addi_count", {25'b0, count_a}, 32'd1);

    // back-to-back burst with in_valid held
    pulse_start(1'b0);
    send(1'b0, 3'd1, 5'd3, 5'd1, 5'd2, 12'h7ff, 1'b0, 1'b1, 6'd0, 32'h0020_81B3);
    send(1'b0, 3'd2, 5'd3, 5'd1, 5'd2, 12'h000, 1'b0, 1'b1, 6'd1, 32'h4020_81B3);
    send(1'b0, 3'd3, 5'd5, 5'd2, 5'd7, 12'd8,   1'b1, 1'b1, 6'd2, 32'h0081_2283);
    idle_inputs();
    @(negedge clk);
    check("burst_done", {31'b0, done_a}, 32'd1);
    check("burst_count", {25'b0, count_a}, 32'd3);
    check("burst_busy", {31'b0, busy_a}, 32'd0);
    @(negedge clk);
    check("burst_done_clr", {31'b0, done_a}, 32'd0);
    check("burst_count_hold", {25'b0, count_a}, 32'd3);

    // SW, start during LOAD ignored, then an illegal kind
    pulse_start(1'b0);
    send(1'b0, 3'd4, 5'd0, 5'd2, 5'd5, 12'd12, 1'b0, 1'b1, 6'd0, 32'h0051_2623);
    idle_inputs();
    pulse_start(1'b0);
    check("start_in_load_busy", {31'b0, busy_a}, 32'd1);
    send(1'b0, 3'd0, 5'd7, 5'd7, 5'd0, 12'hfff, 1'b0, 1'b1, 6'd1, 32'hFFF3_8393);
`ifdef INSTR_ENCODER_ILLEGAL_ERR_EN
    send(1'b0, 3'd6, 5'd1, 5'd1, 5'd1, 12'd1, 1'b1, 1'b0, 6'd0, 32'h0);
    idle_inputs();
    @(negedge clk);
    check("ill_err", {31'b0, err_a}, 32'd1);
    check("ill_ready", {31'b0, ready_a}, 32'd0);
    check("ill_done", {31'b0, done_a}, 32'd0);
    check("ill_count", {25'b0, count_a}, 32'd2);
    pulse_start(1'b0);
    @(negedge clk);
    check("ill_err_clr", {31'b0, err_a}, 32'd0);
    check("ill_idle_busy", {31'b0, busy_a}, 32'd0);
`else
    send(1'b0, 3'd6, 5'd1, 5'd1, 5'd1, 12'd1, 1'b1, 1'b1, 6'd2, 32'h0000_0013);
    idle_inputs();
    @(negedge clk);
    check("ill_done", {31'b0, done_a}, 32'd1);
    check("ill_count", {25'b0, count_a}, 32'd3);
`endif

    // reset mid-burst, with a start pulse during reset
    pulse_start(1'b0);
    send(1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 12'd5, 1'b0, 1'b1, 6'd0, 32'h0050_0093);
    send(1'b0, 3'd1, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, 1'b1, 6'd1, 32'h0020_81B3);
    idle_inputs();
    rst_n = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_a = 1'b0;
    @(negedge clk);
    check("mid_rst_we", {31'b0, we_a}, 32'd0);
    check("mid_rst_addr", {26'b0, addr_a}, 32'd0);
    check("mid_rst_wdata", wdata_a, 32'd0);
    check("mid_rst_busy", {31'b0, busy_a}, 32'd0);
    check("mid_rst_count", {25'b0, count_a}, 32'd0);
    pulse_start(1'b0);
    send(1'b0, 3'd2, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1, 1'b1, 6'd0, 32'h4020_81B3);
    idle_inputs();

    // capacity stop on the 4-word instance
    pulse_start(1'b1);
    send(1'b1, 3'd0, 5'd1, 5'd0, 5'd0, 12'd1, 1'b0, 1'b1, 6'd0, 32'h0010_0093);
    send(1'b1, 3'd0, 5'd2, 5'd0, 5'd0, 12'd2, 1'b0, 1'b1, 6'd1, 32'h0020_0113);
    send(1'b1, 3'd0, 5'd3, 5'd0, 5'd0, 12'd3, 1'b0, 1'b1, 6'd2, 32'h0030_0193);
    send(1'b1, 3'd0, 5'd4, 5'd0, 5'd0, 12'd4, 1'b0, 1'b1, 6'd3, 32'h0040_0213);
    kind = 3'd0; rd = 5'd5; imm = 12'd5;
    @(negedge clk);
    check("cap_ready", {31'b0, ready_b}, 32'd0);
    check("cap_done", {31'b0, done_b}, 32'd1);
    check("cap_count", {29'b0, count_b}, 32'd4);
    repeat (3) begin
      @(negedge clk);
      check("cap_stall_ready", {31'b0, ready_b}, 32'd0);
    end
    check("cap_done_clr", {31'b0, done_b}, 32'd0);
    idle_inputs();

    repeat (3) @(negedge clk);
    check("q_a_empty", q_a.size(), 32'd0);
    check("q_b_empty", q_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential instruction encoder / program loader: the encoding counterpart to the pipeline's opcode/funct3 decoder.
- Accepts field-level instruction requests (kind, rd, rs1, rs2, imm) over a valid/ready handshake and assembles RV32I 32-bit words.
- Writes the words into instruction memory at consecutive word addresses.
- Sits between the bench/boot logic and the imem write port; used to load programs before the core is released from stall.

Parameters:
AW, 6, imem word-address width; capacity DEPTH = 2**AW words
BASE, 0, first imem word address written after start

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low (sampled on rising clk edge)
start  input  1  one-cycle pulse; begins a load session from BASE
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request this cycle
in_kind  input  3  0=ADDI 1=ADD 2=SUB 3=LW 4=SW, 5..7 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  12  immediate (I/S format)
in_last  input  1  marks final request of the program
imem_we  output  1  imem write strobe (imem accepts every cycle)
imem_addr  output  AW  imem word address
imem_wdata  output  32  encoded instruction
busy  output  1  session active (LOAD)
done  output  1  one-cycle pulse when session ends
count  output  AW+1  words written this session

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, count=0. Reset mid-session aborts immediately; no further writes.
- FSM states: IDLE, LOAD, FIN.
  - IDLE -> LOAD on start. Sets the address pointer to BASE and clears count.
  - LOAD -> FIN on an accepted request with in_last=1, or when the accepted request fills the last word (pointer == DEPTH-1).
  - FIN -> IDLE after one cycle, with done=1 during FIN.
  - start outside IDLE is ignored.
- in_ready = (state==LOAD). Accept = in_valid & in_ready.
- Latency is 1 cycle. An accept at edge N drives imem_we=1, imem_addr=pointer and imem_wdata=encoded word during cycle N+1 (all registered). The pointer and count increment on the accept.
- Back-to-back accepts produce one write per cycle with no bubbles.
- imem_we=0 in every cycle without a preceding accept.
- Encodings, as {field...}:
  - ADDI: {imm, rs1, 000, rd, 0010011}
  - ADD: {0000000, rs2, rs1, 000, rd, 0110011}
  - SUB: {0100000, rs2, rs1, 000, rd, 0110011}
  - LW: {imm, rs1, 010, rd, 0000011}
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}
- Unused fields are ignored (e.g., rs2 for ADDI).
- Illegal kind: encoded as NOP 0x00000013 and written normally; counts as a word.
- Wrap: pointer arithmetic is AW bits. Capacity stop prevents wrap within a session. BASE>0 limits the session to DEPTH-BASE words.
- A start pulse coinciding with rst_n=0 has no effect (reset wins).

Optional Feature:
- Macro: INSTR_ENCODER_ILLEGAL_ERR_EN
- Defined:
  - adds output `err` (1 bit, reset 0) and state ERR.
  - An accepted illegal kind writes nothing, sets err=1 and moves to ERR with in_ready=0.
  - ERR -> IDLE only on start (err clears) or on reset. done is not pulsed.
- Undefined: the NOP substitution above; no err port.

Decomposition:
- Shared package `rv32_pkg`:
  - opcode constants (OPC_OP_IMM=0010011, OPC_OP=0110011, OPC_LOAD=0000011, OPC_STORE=0100011)
  - funct3/funct7 constants
  - NOP word
  - kind enum (KIND_ADDI..KIND_SW)
  - FSM state typedef
- The decoder also uses these opcode constants.
- One sub-module `instr_field_pack`: pure combinational kind+fields -> 32-bit word. It is reusable by bench reference models.

Test Plan:
- ADDI x1,x0,5 after start (BASE=0) -> cycle after accept: imem_we=1, addr=0, wdata=0x00500093.
- Burst with in_valid held: ADD x3,x1,x2; SUB x3,x1,x2; LW x5,8(x2) with last=1.
  - Writes 0x002081B3@0, 0x402081B3@1 and 0x00812283@2 on consecutive cycles.
  - Then done=1 for one cycle, count=3, busy=0.
- SW x5,12(x2) -> wdata 0x00512623. Also kind=6 -> 0x00000013 (feature off) or err=1 with no write (feature on).
- Capacity: AW=2 with 5 requests and no last -> exactly 4 writes (addr 0..3), in_ready low after the 4th, done pulse, 5th request stalls.
- Reset mid-burst (rst_n=0 for 1 cycle after 2 accepts) -> no write the following cycle, all outputs at reset values. A new start restarts at BASE.
- in_valid high while IDLE, or start during LOAD -> no writes, no accepts, pointer unchanged.
